// File: rtl/minesweeper_pkg.sv
// Shared types and constants for the minesweeper board engine.
package minesweeper_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {IDLE, READY, SCAN, RESULT, END} state_t;

    // Neighbour offsets, scanned in the order NW, N, NE, W, E, SW, S, SE.
    function automatic logic signed [1:0] nb_drow(input logic [2:0] k);
        case (k)
            3'd0, 3'd1, 3'd2: nb_drow = -2'sd1;
            3'd3, 3'd4:       nb_drow = 2'sd0;
            default:          nb_drow = 2'sd1;
        endcase
    endfunction

    function automatic logic signed [1:0] nb_dcol(input logic [2:0] k);
        case (k)
            3'd0, 3'd3, 3'd5: nb_dcol = -2'sd1;
            3'd1, 3'd6:       nb_dcol = 2'sd0;
            default:          nb_dcol = 2'sd1;
        endcase
    endfunction

endpackage

// File: rtl/ms_neighbour_addr.sv
// Maps a cell index and a neighbour slot k to the neighbour's index,
// flagging neighbours that fall off the board edge (no row/column wrap).
module ms_neighbour_addr
    import minesweeper_pkg::*;
#(
    parameter int ROWS = 5,
    parameter int COLS = 5,
    parameter int N    = ROWS * COLS,
    parameter int IDXW = $clog2(N)
) (
    input  logic [IDXW-1:0] idx,
    input  logic [2:0]      k,
    output logic [IDXW-1:0] nidx,
    output logic            in_board
);

    int r;
    int c;

    always_comb begin
        r        = int'(idx) / COLS + int'(nb_drow(k));
        c        = int'(idx) % COLS + int'(nb_dcol(k));
        in_board = (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
        nidx     = in_board ? IDXW'(r * COLS + c) : '0;
    end

endmodule

// File: rtl/ms_board_engine.sv
// Minesweeper board datapath: serial adjacent-mine count, one-level
// auto-clear around zero cells, win/loss tracking and a saturating win score.
module ms_board_engine
    import minesweeper_pkg::*;
#(
    parameter int ROWS     = 5,
    parameter int COLS     = 5,
    parameter int AUTO_CLR = 1,
    parameter int N        = ROWS * COLS,
    parameter int IDXW     = $clog2(N)
) (
    input  logic             clka,
    input  logic             restart_n,
    input  logic             start,
    input  logic [N-1:0]     mine_map_in,
    input  logic             sel_valid,
    input  logic [IDXW-1:0]  sel_idx,
    output logic             sel_ready,
    output logic             sel_err,
    output logic             result_valid,
    output logic [CNT_W-1:0] n_nearby,
    output logic             gameover,
    output logic             win,
    output logic [N-1:0]     cleared,
    output logic [31:0]      global_score
);

    state_t           state;
    logic [2:0]       k;
    logic [CNT_W-1:0] cnt;
    logic [IDXW-1:0]  idx_q;
    logic [N-1:0]     mine_map;

    logic [IDXW-1:0]  nidx_s;
    logic             inb_s;
    logic             hit;
    logic [CNT_W-1:0] cnt_fin;
    logic [IDXW-1:0]  m_nidx [8];
    logic [7:0]       m_inb;
    logic [N-1:0]     nb_mask;
    logic [N-1:0]     clr_next;
    logic             mine_hit;
    logic             win_next;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    ms_neighbour_addr #(.ROWS(ROWS), .COLS(COLS)) u_scan_addr (
        .idx      (idx_q),
        .k        (k),
        .nidx     (nidx_s),
        .in_board (inb_s)
    );

    // All eight neighbours at once, for the auto-clear mask.
    for (genvar g = 0; g < 8; g++) begin : g_mask
        ms_neighbour_addr #(.ROWS(ROWS), .COLS(COLS)) u_mask_addr (
            .idx      (idx_q),
            .k        (3'(g)),
            .nidx     (m_nidx[g]),
            .in_board (m_inb[g])
        );
    end

    always_comb begin
        hit      = inb_s & mine_map[nidx_s];
        cnt_fin  = cnt + CNT_W'(hit);
        mine_hit = mine_map[idx_q];
        nb_mask  = '0;
        for (int j = 0; j < 8; j++) begin
            if (m_inb[j]) nb_mask[m_nidx[j]] = 1'b1;
        end
        clr_next = cleared | ({{(N-1){1'b0}}, 1'b1} << idx_q);
        if ((AUTO_CLR != 0) && !mine_hit && (cnt_fin == '0)) clr_next = clr_next | nb_mask;
        win_next = !mine_hit && ((clr_next | mine_map) == {N{1'b1}});
    end

    assign sel_ready = (state == READY);

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state        <= IDLE;
            k            <= '0;
            cnt          <= '0;
            idx_q        <= '0;
            mine_map     <= '0;
            sel_err      <= 1'b0;
            result_valid <= 1'b0;
            n_nearby     <= '0;
            gameover     <= 1'b0;
            win          <= 1'b0;
            cleared      <= '0;
            global_score <= '0;
        end else begin
            sel_err      <= 1'b0;
            result_valid <= 1'b0;
            if (start) begin
                mine_map <= mine_map_in;
                cleared  <= '0;
                gameover <= 1'b0;
                win      <= 1'b0;
                n_nearby <= '0;
                k        <= '0;
                cnt      <= '0;
                state    <= READY;
            end else begin
                case (state)
                    READY: begin
                        if (sel_valid) begin
                            if ({1'b0, sel_idx} >= (IDXW+1)'(N)) begin
                                sel_err <= 1'b1;
                            end else begin
                                idx_q <= sel_idx;
                                k     <= '0;
                                cnt   <= '0;
                                state <= SCAN;
                            end
                        end
                    end
                    SCAN: begin
                        cnt <= cnt_fin;
                        k   <= k + 3'd1;
                        // Last neighbour: publish the result on this same edge.
                        if (k == 3'd7) begin
                            state        <= RESULT;
                            result_valid <= 1'b1;
                            cleared      <= clr_next;
                            if (mine_hit) begin
                                gameover <= 1'b1;
                                n_nearby <= '0;
                            end else if (win_next) begin
                                win          <= 1'b1;
                                gameover     <= 1'b1;
                                n_nearby     <= '0;
                                global_score <= sat_inc(global_score);
                            end else begin
                                n_nearby <= cnt_fin;
                            end
                        end
                    end
                    RESULT:  state <= gameover ? END : READY;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ms_board_engine.sv
// Directed bench for ms_board_engine on a 5x5 board with a behavioural board model.
module tb_ms_board_engine;

    localparam int R  = 5;
    localparam int C  = 5;
    localparam int NC = R * C;
    localparam logic [24:0] MAP = 25'h000802A;

    logic        clka = 1'b0;
    logic        restart_n = 1'b0;
    logic        start = 1'b0;
    logic [24:0] mine_map_in = '0;
    logic        sel_valid = 1'b0;
    logic [4:0]  sel_idx = '0;
    logic        sel_ready;
    logic        sel_err;
    logic        result_valid;
    logic [3:0]  n_nearby;
    logic        gameover;
    logic        win;
    logic [24:0] cleared;
    logic [31:0] global_score;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic        exp_ready, exp_err, exp_rv, exp_go, exp_win;
    logic [3:0]  exp_n;
    logic [24:0] exp_clr, m_map;
    logic [31:0] exp_score;

    always #5 clka = ~clka;

    ms_board_engine #(.ROWS(R), .COLS(C), .AUTO_CLR(1)) dut (
        .clka         (clka),
        .restart_n    (restart_n),
        .start        (start),
        .mine_map_in  (mine_map_in),
        .sel_valid    (sel_valid),
        .sel_idx      (sel_idx),
        .sel_ready    (sel_ready),
        .sel_err      (sel_err),
        .result_valid (result_valid),
        .n_nearby     (n_nearby),
        .gameover     (gameover),
        .win          (win),
        .cleared      (cleared),
        .global_score (global_score)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clka) begin
        if (chk_en) begin
            chk("sel_ready",    32'(sel_ready),    32'(exp_ready));
            chk("sel_err",      32'(sel_err),      32'(exp_err));
            chk("result_valid", 32'(result_valid), 32'(exp_rv));
            chk("n_nearby",     32'(n_nearby),     32'(exp_n));
            chk("gameover",     32'(gameover),     32'(exp_go));
            chk("win",          32'(win),          32'(exp_win));
            chk("cleared",      32'(cleared),      32'(exp_clr));
            chk("global_score", global_score,      exp_score);
        end
    end

    function automatic int model_count(input int idx);
        int r = idx / C;
        int c = idx % C;
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) && r+dr >= 0 && r+dr < R && c+dc >= 0 && c+dc < C)
                    if (m_map[(r+dr)*C + c + dc]) n++;
        return n;
    endfunction

    function automatic logic [24:0] model_nbrs(input int idx);
        int r = idx / C;
        int c = idx % C;
        logic [24:0] m = '0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (r+dr >= 0 && r+dr < R && c+dc >= 0 && c+dc < C)
                    m[(r+dr)*C + c + dc] = 1'b1;
        return m;
    endfunction

    task automatic do_start(input logic [24:0] m);
        @(negedge clka);
        start = 1'b1;
        mine_map_in = m;
        @(posedge clka);
        #1;
        start = 1'b0;
        m_map = m;
        exp_clr = '0; exp_go = 1'b0; exp_win = 1'b0; exp_n = '0;
        exp_rv = 1'b0; exp_err = 1'b0; exp_ready = 1'b1;
    endtask

    task automatic do_select(input int idx);
        int n;
        logic [24:0] clr;
        @(negedge clka);
        sel_valid = 1'b1;
        sel_idx = 5'(idx);
        @(posedge clka);
        #1;
        sel_valid = 1'b0;
        if (idx >= NC) begin
            exp_err = 1'b1;
            @(posedge clka);
            #1;
            exp_err = 1'b0;
            return;
        end
        exp_ready = 1'b0;
        n = model_count(idx);
        clr = exp_clr | (25'd1 << idx);
        repeat (7) @(posedge clka);
        @(posedge clka);
        #1;
        exp_rv = 1'b1;
        if (m_map[idx]) begin
            exp_go = 1'b1;
            exp_n = '0;
        end else begin
            if (n == 0) clr = clr | model_nbrs(idx);
            if ((clr | m_map) == 25'h1FF_FFFF) begin
                exp_win = 1'b1; exp_go = 1'b1; exp_n = '0;
                exp_score = exp_score + 1;
            end else begin
                exp_n = 4'(n);
            end
        end
        exp_clr = clr;
        @(posedge clka);
        #1;
        exp_rv = 1'b0;
        exp_ready = !exp_go;
    endtask

    initial begin
        exp_ready = 0; exp_err = 0; exp_rv = 0; exp_go = 0; exp_win = 0;
        exp_n = '0; exp_clr = '0; m_map = '0; exp_score = '0;
        #2;
        chk("rst_ready",  32'(sel_ready), 0);
        chk("rst_rv",     32'(result_valid), 0);
        chk("rst_clr",    32'(cleared), 0);
        chk("rst_score",  global_score, 0);
        @(negedge clka);
        restart_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(posedge clka);

        // Game 1: counts, wrap exclusion, auto-clear, mine hit.
        do_start(MAP);
        do_select(0);
        chk("lit_n0",   32'(n_nearby), 2);
        chk("lit_clr0", 32'(cleared), 32'h1);
        do_select(4);
        chk("lit_n4",   32'(n_nearby), 1);
        do_select(12);
        chk("lit_n12",   32'(n_nearby), 0);
        chk("lit_clr12", 32'(cleared), 32'h00739D1);
        do_select(3);
        chk("lit_go3",    32'(gameover), 1);
        chk("lit_ready3", 32'(sel_ready), 0);
        @(negedge clka);
        sel_valid = 1'b1;
        sel_idx = 5'd7;
        repeat (4) @(posedge clka);
        #1;
        sel_valid = 1'b0;
        chk("lit_end_clr", 32'(cleared), 32'h00739D9);

        // Game 2: out-of-range index, then clear every safe cell.
        do_start(MAP);
        do_select(27);
        for (int i = 0; i < NC; i++)
            if (!m_map[i] && !exp_win) do_select(i);
        chk("lit_win",   32'(win), 1);
        chk("lit_score", global_score, 1);

        // Start during SCAN aborts the selection.
        do_start(MAP);
        @(negedge clka);
        sel_valid = 1'b1;
        sel_idx = 5'd12;
        @(posedge clka);
        #1;
        sel_valid = 1'b0;
        exp_ready = 1'b0;
        repeat (3) @(posedge clka);
        do_start(MAP);
        repeat (12) @(posedge clka);
        #1;
        chk("lit_abort_clr", 32'(cleared), 0);
        do_select(12);
        chk("lit_n12b", 32'(n_nearby), 0);

        // Asynchronous reset mid-cycle.
        #1;
        restart_n = 1'b0;
        exp_ready = 0; exp_err = 0; exp_rv = 0; exp_go = 0; exp_win = 0;
        exp_n = '0; exp_clr = '0; m_map = '0; exp_score = '0;
        #1;
        chk("async_clr",   32'(cleared), 0);
        chk("async_score", global_score, 0);
        chk("async_ready", 32'(sel_ready), 0);
        @(negedge clka);
        restart_n = 1'b1;
        repeat (3) @(posedge clka);

        // Empty map is not a win before any selection.
        do_start(25'h0);
        repeat (4) @(posedge clka);
        #1;
        chk("lit_empty_win", 32'(win), 0);

        @(negedge clka);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
